// File: rtl/complex_addsub_issue_ctrl_pkg.sv
// complex_addsub_issue_ctrl_pkg: shared lane/counter widths and FSM encoding for the complex add/sub issue controller
package complex_addsub_issue_ctrl_pkg;
   localparam int HALF_W = 32;
   localparam int CNT_WIDTH = 16;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/complex_addsub_issue_ctrl_fifo.sv
// cplx_result_fifo: synchronous result buffer, extra pointer bit separates full from empty
//   clk, rst_n      clock, asynchronous active-low reset
//   push/push_data  write one result
//   pop             consume the head (ignored when empty)
//   head            head entry, 0 when empty
//   count/full/empty occupancy status
module cplx_result_fifo import complex_addsub_issue_ctrl_pkg::*; #(
   parameter int DATA_W = 2 * HALF_W,
   parameter int FIFO_DEPTH = 8,
   localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1,
   localparam int PW = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [PW-1:0]     count,
   output logic              full,
   output logic              empty
);
   logic [DATA_W-1:0] mem [2**AW];
   logic [PW-1:0] wr_ptr, rd_ptr;
   assign count = wr_ptr - rd_ptr;
   assign full = count == PW'(FIFO_DEPTH);
   assign empty = wr_ptr == rd_ptr;
   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
      end
   always_ff @(posedge clk)
      if (rst_n) assert (!(push && full && !pop));
endmodule

// File: rtl/complex_addsub_issue_ctrl.sv
// complex_addsub_issue_ctrl: issues complex operand pairs into a fixed-latency adder and buffers its results
//   start/length        job start (IDLE only) and number of operand pairs
//   in_*                operand stream (valid/ready), in_op 0=add 1=subtract
//   add_a/add_b/add_op  registered operands to the adder, add_ce = busy
//   add_result          adder output, LATENCY cycles after the pair was accepted
//   capture             add_result carries a real result this cycle
//   out_*               buffered results (valid/ready)
//   busy/done           job active / one-cycle pulse after the last result is popped
module complex_addsub_issue_ctrl import complex_addsub_issue_ctrl_pkg::*; #(
   parameter int LATENCY = 8,
   parameter int DATA_W = 2 * HALF_W,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W = CNT_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  length,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_op,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   output logic              add_op,
   output logic              add_ce,
   input  logic [DATA_W-1:0] add_result,
   output logic              capture,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);
   localparam int PW = (FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1) + 1;
   localparam int OW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;
   state_t state;
   logic [CNT_W-1:0] len, issued_cnt, popped_cnt, popped_nxt;
   logic [LATENCY-1:0] vld_sr;
   logic [OW-1:0] inflight;
   logic [PW-1:0] fifo_count;
   logic issue, pop, fifo_full, fifo_empty;
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + OW'(vld_sr[i]);
   end
   // A pair is only accepted if a FIFO slot is reserved for it: slots held = buffered + in flight
   assign in_ready = state == RUN && issued_cnt < len && !fifo_full
                     && OW'(fifo_count) + inflight < OW'(FIFO_DEPTH);
   assign issue = in_valid && in_ready;
   assign capture = vld_sr[LATENCY-1];
   assign out_valid = !fifo_empty;
   assign pop = out_valid && out_ready;
   assign popped_nxt = popped_cnt + CNT_W'(pop);
   assign add_ce = busy;
   cplx_result_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(capture), .push_data(add_result), .pop(pop),
      .head(out_data), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         add_a <= '0;
         add_b <= '0;
         add_op <= 1'b0;
         vld_sr <= '0;
      end else begin
         vld_sr <= {vld_sr[LATENCY-2:0], issue};
         if (issue) begin
            add_a <= in_a;
            add_b <= in_b;
            add_op <= in_op;
         end
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         len <= '0;
         issued_cnt <= '0;
         popped_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (issue) issued_cnt <= issued_cnt + CNT_W'(1);
         if (pop) popped_cnt <= popped_nxt;
         case (state)
            IDLE: if (start) begin
               len <= length;
               issued_cnt <= '0;
               popped_cnt <= '0;
               if (length != '0) begin
                  state <= RUN;
                  busy <= 1'b1;
               end else done <= 1'b1;
            end
            RUN: if (issued_cnt == len) state <= DRAIN;
            DRAIN: if (popped_nxt == len) begin
               state <= IDLE;
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_complex_addsub_issue_ctrl.sv
// tb_complex_addsub_issue_ctrl: directed jobs against a job-level model of the issue controller
module tb_complex_addsub_issue_ctrl;
   localparam int L = 8, DW = 64, D = 8, CW = 16;
   logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_op = 0, out_ready = 0;
   logic [CW-1:0] length = '0;
   logic [DW-1:0] in_a = '0, in_b = '0;
   logic [DW-1:0] add_a, add_b, add_result, out_data;
   logic in_ready, add_op, add_ce, capture, out_valid, busy, done;
   int n_cmp = 0, n_err = 0;
   int cyc = 0, m_len = 0, m_acc = 0, m_pop = 0, m_cap = 0;
   bit m_active = 0, m_done = 0;
   int cap_q[$];
   logic [DW-1:0] res_q[$];
   int acc_t[$], cap_t[$];
   logic [DW-1:0] got_q[$];
   int done_cnt = 0, rdy_cnt = 0, fed = 0;
   always #5 clk = ~clk;

   complex_addsub_issue_ctrl #(.LATENCY(L), .DATA_W(DW), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .length(length),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_ce(add_ce), .add_result(add_result),
      .capture(capture), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   function automatic logic [DW-1:0] cplx(logic [DW-1:0] a, logic [DW-1:0] b, logic op);
      logic [31:0] re, im;
      re = op ? a[63:32] - b[63:32] : a[63:32] + b[63:32];
      im = op ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
      return {re, im};
   endfunction

   // adder: add_a/add_b are its first stage, L-1 more stages follow
   logic [DW-1:0] pipe [L-1];
   always @(posedge clk)
      if (add_ce) begin
         pipe[0] <= cplx(add_a, add_b, add_op);
         for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
      end
   assign add_result = pipe[L-2];

   function automatic bit e_ready();
      return m_active && m_acc < m_len && (m_acc - m_pop) < D;
   endfunction

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // model: every accepted pair holds one result slot until popped; its result appears L cycles after acceptance
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 0; m_done = 0; m_len = 0; m_acc = 0; m_pop = 0; m_cap = 0;
         cap_q.delete(); res_q.delete();
      end else begin
         bit rdy, cap, popx;
         rdy = e_ready();
         cap = cap_q.size() > 0 && cap_q[0] == cyc;
         popx = m_cap > m_pop && out_ready;
         m_done = 0;
         if (in_valid && rdy) begin
            cap_q.push_back(cyc + L);
            res_q.push_back(cplx(in_a, in_b, in_op));
            m_acc++;
         end
         if (cap) begin
            m_cap++;
            void'(cap_q.pop_front());
         end
         if (popx) m_pop++;
         if (!m_active && start) begin
            m_len = int'(length); m_acc = 0; m_pop = 0; m_cap = 0;
            cap_q.delete(); res_q.delete();
            m_active = length != 0;
            m_done = length == 0;
         end else if (m_active && popx && m_pop == m_len) begin
            m_active = 0;
            m_done = 1;
         end
         cyc++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("in_ready", in_ready, e_ready());
         chk("capture", capture, cap_q.size() > 0 && cap_q[0] == cyc);
         chk("out_valid", out_valid, m_cap > m_pop);
         if (m_cap > m_pop) chk("out_data", out_data, res_q[m_pop]);
         chk("busy", busy, m_active);
         chk("add_ce", add_ce, m_active);
         chk("done", done, m_done);
         if (in_valid && in_ready) acc_t.push_back(cyc);
         if (capture) cap_t.push_back(cyc);
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (done) done_cnt++;
         if (in_ready) rdy_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      acc_t.delete(); cap_t.delete(); got_q.delete();
      done_cnt = 0; rdy_cnt = 0;
   endtask

   task automatic start_job(int n);
      length = CW'(n);
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic set_ops(int i, int mode);
      if (mode == 0) begin
         in_a = {32'(i + 1), 32'(2 * (i + 1))};
         in_b = {32'(10 * (i + 1)), 32'(20 * (i + 1))};
         in_op = 0;
      end else if (mode == 1) begin
         in_a = {32'd5, 32'hFFFF_FFFD};
         in_b = {32'd2, 32'd7};
         in_op = 1;
      end else begin
         in_a = {32'(i * 3 + 1), 32'(100 - i)};
         in_b = {32'(i + 10), 32'(-7 * i)};
         in_op = i[0];
      end
   endtask

   task automatic feed(int n, bit alt, int mode);
      int k = 0;
      fed = 0;
      while (fed < n && k < 3000) begin
         in_valid = !alt || k % 2 == 0;
         set_ops(fed, mode);
         @(negedge clk);
         if (in_valid && in_ready) fed++;
         tick();
         k++;
      end
      in_valid = 0;
      chk("feed_count", fed, n);
   endtask

   task automatic wait_done(int max);
      int k;
      for (k = 0; k < max; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_timeout", k < max, 1'b1);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_add_ce", add_ce, 0);
      chk("rst_capture", capture, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_add_op", add_op, 0);
      chk("rst_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      tick();

      // plain 4-pair add job
      out_ready = 1;
      clear_mon();
      start_job(4);
      feed(4, 0, 0);
      wait_done(100);
      chk("t1_ready_cycles", rdy_cnt, 4);
      chk("t1_captures", cap_t.size(), 4);
      chk("t1_first_latency", cap_t[0] - acc_t[0], L);
      chk("t1_capture_run", cap_t[3] - cap_t[0], 3);
      chk("t1_res0", got_q[0], {32'd11, 32'd22});
      chk("t1_res3", got_q[3], {32'd44, 32'd88});
      chk("t1_done_pulses", done_cnt, 1);

      // 20 pairs against a stalled consumer
      out_ready = 0;
      clear_mon();
      start_job(20);
      fork
         feed(20, 0, 2);
         begin
            repeat (30) tick();
            chk("t2_accepted_stalled", fed, 8);
            chk("t2_captured_stalled", cap_t.size(), 8);
            chk("t2_in_ready_stalled", in_ready, 0);
            out_ready = 1;
         end
      join
      wait_done(300);
      chk("t2_pops", got_q.size(), 20);
      chk("t2_res0", got_q[0], {32'd11, 32'd100});
      chk("t2_res19", got_q[19], {32'd29, 32'd214});
      chk("t2_done_pulses", done_cnt, 1);

      // subtract with bubbles every other cycle
      clear_mon();
      start_job(4);
      feed(4, 1, 1);
      wait_done(100);
      chk("t3_res0", got_q[0], {32'd3, 32'hFFFF_FFF6});
      chk("t3_res3", got_q[3], {32'd3, 32'hFFFF_FFF6});
      chk("t3_spacing01", cap_t[1] - cap_t[0], 2);
      chk("t3_spacing23", cap_t[3] - cap_t[2], 2);

      // zero-length job
      clear_mon();
      start_job(0);
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 0);
      chk("t4_in_ready", in_ready, 0);
      tick();
      chk("t4_done_drop", done, 0);
      chk("t4_busy_after", busy, 0);

      // reset during drain with 3 results in flight
      clear_mon();
      start_job(3);
      feed(3, 0, 2);
      repeat (2) tick();
      chk("t5_busy_before", busy, 1);
      #2 rst_n = 0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_add_ce", add_ce, 0);
      chk("t5_rst_capture", capture, 0);
      chk("t5_rst_out_valid", out_valid, 0);
      chk("t5_rst_add_a", add_a, 0);
      chk("t5_rst_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      clear_mon();
      repeat (15) tick();
      chk("t5_no_capture", cap_t.size(), 0);
      chk("t5_no_output", got_q.size(), 0);
      start_job(2);
      feed(2, 0, 0);
      wait_done(100);
      chk("t5_res0", got_q[0], {32'd11, 32'd22});
      chk("t5_res1", got_q[1], {32'd22, 32'd44});

      // start pulsed while running is ignored
      clear_mon();
      start_job(6);
      fork
         feed(6, 0, 2);
         begin
            repeat (2) tick();
            length = 2;
            start = 1;
            tick();
            start = 0;
         end
      join
      wait_done(200);
      repeat (12) tick();
      chk("t6_done_pulses", done_cnt, 1);
      chk("t6_pops", got_q.size(), 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
